// File: rtl/dm_cache_pkg.sv
// ----------------------------------------------------------------------------
// dm_cache_pkg
// Shared definitions for the direct-mapped read-only cache controller:
// address geometry, line/word widths, main-memory size and latency,
// the controller FSM state type and address-field helper functions.
// ----------------------------------------------------------------------------
package dm_cache_pkg;

   localparam int ADDR_W         = 15;
   localparam int INDEX_BITS     = 10;
   localparam int WORD_W         = 32;
   localparam int WORDS_PER_LINE = 4;
   localparam int OFFSET_W       = $clog2(WORDS_PER_LINE);
   localparam int LINE_W         = WORDS_PER_LINE * WORD_W;
   localparam int TAG_W          = ADDR_W - INDEX_BITS - OFFSET_W;
   localparam int NUM_LINES      = 1 << INDEX_BITS;
   localparam int MEM_WORDS      = 32000;
   localparam int MEM_LATENCY    = 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOOKUP,
      ST_FETCH,
      ST_RESPOND
   } state_t;

   function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
      return addr[ADDR_W-1:INDEX_BITS+OFFSET_W];
   endfunction

   function automatic logic [INDEX_BITS-1:0] addr_index(input logic [ADDR_W-1:0] addr);
      return addr[INDEX_BITS+OFFSET_W-1:OFFSET_W];
   endfunction

   function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] addr);
      return addr[OFFSET_W-1:0];
   endfunction

   // Word k of a line occupies bits [32k+31:32k].
   function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                   input logic [OFFSET_W-1:0] off);
      return line[off*WORD_W +: WORD_W];
   endfunction

endpackage

// File: rtl/dm_cache_store.sv
// ----------------------------------------------------------------------------
// dm_cache_store
// Valid/tag/data arrays of the direct-mapped cache.
//   clk, rst  : clock, asynchronous active-high reset (clears valid bits only)
//   rd_index  : line index for the combinational read port
//   rd_valid, rd_tag, rd_line : contents of line rd_index
//   wr_en, wr_index, wr_tag, wr_line : synchronous line fill, sets valid
// ----------------------------------------------------------------------------
module dm_cache_store
   import dm_cache_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [INDEX_BITS-1:0] rd_index,
   output logic                  rd_valid,
   output logic [TAG_W-1:0]      rd_tag,
   output logic [LINE_W-1:0]     rd_line,
   input  logic                  wr_en,
   input  logic [INDEX_BITS-1:0] wr_index,
   input  logic [TAG_W-1:0]      wr_tag,
   input  logic [LINE_W-1:0]     wr_line
);

   logic [NUM_LINES-1:0] valid_q, valid_d;
   logic [TAG_W-1:0]     tag_q  [NUM_LINES];
   logic [LINE_W-1:0]    data_q [NUM_LINES];

   always_comb begin
      valid_d = valid_q;
      if (wr_en) begin
         valid_d[wr_index] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
      end else begin
         valid_q <= valid_d;
      end
   end

   // NOTE: tag and data arrays have no reset; the valid bits alone decide
   // whether a line's contents mean anything, which keeps these as plain RAM.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_q[wr_index]  <= wr_tag;
         data_q[wr_index] <= wr_line;
      end
   end

   assign rd_valid = valid_q[rd_index];
   assign rd_tag   = tag_q[rd_index];
   assign rd_line  = data_q[rd_index];

endmodule

// File: rtl/dm_cache_ctrl.sv
// ----------------------------------------------------------------------------
// dm_cache_ctrl
// Direct-mapped, read-only cache controller between a CPU requester and
// main memory. One request outstanding at a time.
//   clk, rst      : clock, asynchronous active-high reset
//   req_valid/req_ready/req_addr : request handshake, word address
//   resp_valid    : one-cycle response pulse; resp_data / resp_hit qualify it
//   mem_addr      : block-aligned fetch address, mem_data : 128-bit block
//   access_count, hit_count : response statistics (wrap modulo 2^32)
// Build option: define CACHE_STATS_EN to build the statistics counters;
// otherwise both count outputs are tied to zero.
// ----------------------------------------------------------------------------
module dm_cache_ctrl
   import dm_cache_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              resp_valid,
   output logic [WORD_W-1:0] resp_data,
   output logic              resp_hit,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [LINE_W-1:0] mem_data,
   output logic [31:0]       access_count,
   output logic [31:0]       hit_count
);

   localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LATENCY - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [WORD_W-1:0] resp_data_q, resp_data_d;
   logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;

   logic              rd_valid;
   logic [TAG_W-1:0]  rd_tag;
   logic [LINE_W-1:0] rd_line;
   logic              wr_en;
   logic              in_range;
   logic              lookup_hit;
   logic [WORD_W-1:0] hit_word;

   dm_cache_store u_store (
      .clk      (clk),
      .rst      (rst),
      .rd_index (addr_index(addr_q)),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .rd_line  (rd_line),
      .wr_en    (wr_en),
      .wr_index (addr_index(addr_q)),
      .wr_tag   (addr_tag(addr_q)),
      .wr_line  (mem_data)
   );

   assign in_range   = addr_q < ADDR_W'(MEM_WORDS);
   assign lookup_hit = rd_valid && (rd_tag == addr_tag(addr_q));
   assign hit_word   = line_word(rd_line, addr_offset(addr_q));
   assign mem_addr   = mem_addr_q;

   // NOTE: every signal assigned here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      mem_addr_d  = mem_addr_q;
      resp_data_d = resp_data_q;
      lat_cnt_d   = lat_cnt_q;
      wr_en       = 1'b0;
      req_ready   = 1'b0;
      resp_valid  = 1'b0;
      resp_hit    = 1'b0;
      resp_data   = resp_data_q;

      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               addr_d  = req_addr;
               state_d = ST_LOOKUP;
            end
         end
         ST_LOOKUP: begin
            if (!in_range) begin
               resp_data_d = '0;
               state_d     = ST_RESPOND;
            end else if (lookup_hit) begin
               // Hit is answered combinationally in this cycle; the register
               // copy keeps resp_data stable after the pulse.
               resp_valid  = 1'b1;
               resp_hit    = 1'b1;
               resp_data   = hit_word;
               resp_data_d = hit_word;
               state_d     = ST_IDLE;
            end else begin
               mem_addr_d = {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
               lat_cnt_d  = '0;
               state_d    = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (lat_cnt_q == LAT_LAST) begin
               wr_en       = 1'b1;
               resp_data_d = line_word(mem_data, addr_offset(addr_q));
               state_d     = ST_RESPOND;
            end else begin
               lat_cnt_d = lat_cnt_q + LAT_W'(1);
            end
         end
         ST_RESPOND: begin
            resp_valid = 1'b1;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         mem_addr_q  <= '0;
         resp_data_q <= '0;
         lat_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         mem_addr_q  <= mem_addr_d;
         resp_data_q <= resp_data_d;
         lat_cnt_q   <= lat_cnt_d;
      end
   end

`ifdef CACHE_STATS_EN
   logic [31:0] access_q, access_d;
   logic [31:0] hits_q, hits_d;

   always_comb begin
      access_d = access_q;
      hits_d   = hits_q;
      if (resp_valid) begin
         access_d = access_q + 32'd1;
         if (resp_hit) begin
            hits_d = hits_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         access_q <= '0;
         hits_q   <= '0;
      end else begin
         access_q <= access_d;
         hits_q   <= hits_d;
      end
   end

   assign access_count = access_q;
   assign hit_count    = hits_q;
`else
   assign access_count = 32'd0;
   assign hit_count    = 32'd0;
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// ----------------------------------------------------------------------------
// tb_dm_cache_ctrl
// Directed bench for dm_cache_ctrl. A driver issues requests and pushes the
// hand-computed expected response into a scoreboard queue; a monitor pops
// and compares whenever resp_valid is seen. Main memory is modelled as a
// word array preloaded with 0xC0DE0000|addr, except words 0x40..0x43.
// Counter expectations follow the CACHE_STATS_EN build option.
// ----------------------------------------------------------------------------
module tb_dm_cache_ctrl;

   typedef struct {
      logic [14:0] addr;
      logic [31:0] data;
      bit          hit;
      int          lat;
      bit          chk_mem;
      logic [14:0] mem_addr;
      int          acc_cyc;
   } exp_t;

`ifdef CACHE_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [14:0]   req_addr = '0;
   logic          resp_valid;
   logic [31:0]   resp_data;
   logic          resp_hit;
   logic [14:0]   mem_addr;
   logic [127:0]  mem_data;
   logic [31:0]   access_count;
   logic [31:0]   hit_count;

   logic [31:0]   mem [0:32767];
   exp_t          sb_q[$];
   int            cyc = 0;
   int            pass_cnt = 0;
   int            total_cnt = 0;
   int            acc_m = 0;
   int            hit_m = 0;

   dm_cache_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_addr     (req_addr),
      .resp_valid   (resp_valid),
      .resp_data    (resp_data),
      .resp_hit     (resp_hit),
      .mem_addr     (mem_addr),
      .mem_data     (mem_data),
      .access_count (access_count),
      .hit_count    (hit_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign mem_data = {mem[{mem_addr[14:2], 2'd3}], mem[{mem_addr[14:2], 2'd2}],
                      mem[{mem_addr[14:2], 2'd1}], mem[{mem_addr[14:2], 2'd0}]};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Issue one request; hold keeps req_valid high for a back-to-back follow-up.
   task automatic issue(input logic [14:0] a, input logic [31:0] d, input bit h,
                        input int lat, input bit chk, input logic [14:0] ma, input bit hold);
      exp_t e;
      int   n = 0;
      @(negedge clk);
      req_valid = 1'b1;
      req_addr  = a;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("req_ready_timeout", {31'd0, req_ready}, 32'd1);
      e.addr = a; e.data = d; e.hit = h; e.lat = lat;
      e.chk_mem = chk; e.mem_addr = ma; e.acc_cyc = cyc;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (!hold) req_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("drain_timeout", 32'(sb_q.size()), 32'd0);
      @(negedge clk);
   endtask

   task automatic check_counts(input string tag, input int acc, input int hits);
      check({tag, "_access_count"}, access_count, STATS ? 32'(acc) : 32'd0);
      check({tag, "_hit_count"}, hit_count, STATS ? 32'(hits) : 32'd0);
   endtask

   // Monitor / scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            acc_m = 0;
            hit_m = 0;
         end else if (resp_valid) begin
            if (sb_q.size() == 0) begin
               check("unexpected_resp", {31'd0, resp_valid}, 32'd0);
            end else begin
               e = sb_q.pop_front();
               check($sformatf("resp_data@%h", e.addr), resp_data, e.data);
               check($sformatf("resp_hit@%h", e.addr), {31'd0, resp_hit}, {31'd0, e.hit});
               check($sformatf("resp_latency@%h", e.addr), 32'(cyc - e.acc_cyc), 32'(e.lat));
               if (e.chk_mem)
                  check($sformatf("mem_addr@%h", e.addr), {17'd0, mem_addr}, {17'd0, e.mem_addr});
               check("access_count_pre", access_count, STATS ? 32'(acc_m) : 32'd0);
               check("hit_count_pre", hit_count, STATS ? 32'(hit_m) : 32'd0);
               acc_m++;
               if (e.hit) hit_m++;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 32768; i++) mem[i] = 32'hC0DE0000 | 32'(i);
      mem[15'h40] = 32'hA0A0_0000;
      mem[15'h41] = 32'hA1A1_1111;
      mem[15'h42] = 32'hA2A2_2222;
      mem[15'h43] = 32'hA3A3_3333;

      repeat (3) @(negedge clk);
      check("rst_req_ready", {31'd0, req_ready}, 32'd1);
      check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst_resp_hit", {31'd0, resp_hit}, 32'd0);
      check("rst_resp_data", resp_data, 32'd0);
      check("rst_mem_addr", {17'd0, mem_addr}, 32'd0);
      check_counts("rst", 0, 0);
      rst = 1'b0;

      // Cold miss, then hit in the same line
      issue(15'h0041, 32'hA1A1_1111, 1'b0, 3, 1'b1, 15'h0040, 1'b0);
      drain();
      check_counts("cold_miss", 1, 0);
      issue(15'h0043, 32'hA3A3_3333, 1'b1, 1, 1'b0, 15'h0000, 1'b0);
      drain();
      check_counts("same_line_hit", 2, 1);

      // Conflict eviction: same index 0x10, tags 1 and 0
      issue(15'h1042, 32'hC0DE_1042, 1'b0, 3, 1'b1, 15'h1040, 1'b0);
      issue(15'h0040, 32'hA0A0_0000, 1'b0, 3, 1'b1, 15'h0040, 1'b0);
      drain();
      check_counts("conflict", 4, 1);
      issue(15'h0042, 32'hA2A2_2222, 1'b1, 1, 1'b0, 15'h0000, 1'b0);

      // Last in-range word, then out of range twice (no fill, mem_addr held)
      issue(15'h7CFF, 32'hC0DE_7CFF, 1'b0, 3, 1'b1, 15'h7CFC, 1'b0);
      drain();
      repeat (3) @(negedge clk);
      check("resp_data_hold", resp_data, 32'hC0DE_7CFF);
      issue(15'h7D00, 32'h0000_0000, 1'b0, 2, 1'b1, 15'h7CFC, 1'b0);
      issue(15'h7D00, 32'h0000_0000, 1'b0, 2, 1'b1, 15'h7CFC, 1'b0);
      drain();
      check("resp_data_hold_oor", resp_data, 32'd0);
      check_counts("oor", 8, 2);

      // Reset while in FETCH: no response, state cleared
      @(negedge clk);
      req_valid = 1'b1;
      req_addr  = 15'h1041;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("fetch_mem_addr", {17'd0, mem_addr}, 32'h0000_1040);
      #2 rst = 1'b1;
      repeat (2) @(negedge clk);
      check("midrst_req_ready", {31'd0, req_ready}, 32'd1);
      check("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("midrst_mem_addr", {17'd0, mem_addr}, 32'd0);
      check_counts("midrst", 0, 0);
      #2 rst = 1'b0;
      repeat (5) @(negedge clk);
      check("midrst_queue_empty", 32'(sb_q.size()), 32'd0);

      // Re-read misses; previously valid line 0x40 was invalidated by reset
      issue(15'h1041, 32'hC0DE_1041, 1'b0, 3, 1'b1, 15'h1040, 1'b0);
      issue(15'h0041, 32'hA1A1_1111, 1'b0, 3, 1'b1, 15'h0040, 1'b0);
      drain();

      // Back-to-back with req_valid held: one miss then three hits
      issue(15'h0302, 32'hC0DE_0302, 1'b0, 3, 1'b1, 15'h0300, 1'b1);
      issue(15'h0300, 32'hC0DE_0300, 1'b1, 1, 1'b0, 15'h0000, 1'b1);
      issue(15'h0303, 32'hC0DE_0303, 1'b1, 1, 1'b0, 15'h0000, 1'b1);
      issue(15'h0301, 32'hC0DE_0301, 1'b1, 1, 1'b0, 15'h0000, 1'b0);
      drain();
      check_counts("final", 6, 3);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
